// File: rtl/uart_pkg.sv
// Shared definitions for the parameterised UART transmitter:
// FSM state encoding, parity mode constants and a parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Wide enough to index 9 data bits (0..8) or 2 stop bits (0..1).
    localparam int BIT_IDX_W = 4;

    // Parity over the low nbits of word: even = XOR of the data bits,
    // odd = its inverse. Unused upper bits are ignored.
    function automatic logic parity_of(input logic [8:0] word,
                                       input int         nbits,
                                       input int         mode);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < nbits) p = p ^ word[i];
        end
        return (mode == PARITY_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO for the transmit path. Registered pointers and
// occupancy count; the head word is presented combinationally on dout.
// Push into a full FIFO and pop from an empty FIFO are ignored.
module uart_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: a transmit FIFO feeding a framing FSM.
// Frame = start bit, DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits; every bit lasts exactly CLK_DIV clocks.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_DIV     = 10417,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 busy,
    output logic                 done
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_IDX_W-1:0] DATA_LAST = BIT_IDX_W'(DATA_BITS - 1);
    localparam logic [BIT_IDX_W-1:0] STOP_LAST = BIT_IDX_W'(STOP_BITS - 1);

    // Elaboration-time guards on the legal parameter space.
    if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
        $error("uart_tx_param: CLK_DIV must be in 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be in 5..9");
    end
    if (PARITY_MODE < PARITY_NONE || PARITY_MODE > PARITY_ODD) begin : g_bad_parity
        $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
    end

    tx_state_e               state;
    logic [DIV_W-1:0]        div_cnt;
    logic [BIT_IDX_W-1:0]    bit_idx;
    logic [DATA_BITS-1:0]    shreg;
    logic                    par_bit;
    logic                    txd_r;

    logic                    bit_end;
    logic                    frame_end;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [DATA_BITS-1:0]    fifo_dout;
    logic [CNT_W-1:0]        fifo_count;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid),
        .din   (tx_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // The divider only runs inside a frame and restarts at every bit, so the
    // first bit edge is locked to the pop edge rather than a free-running tick.
    assign bit_end   = (div_cnt == DIV_LAST);
    assign frame_end = (state == ST_STOP) && bit_end && (bit_idx == STOP_LAST);

    // A frame is launched from IDLE, or straight out of the last stop bit so
    // that queued words follow with no idle gap.
    assign fifo_pop  = !fifo_empty && ((state == ST_IDLE) || frame_end);

    // No credit for a same-cycle pop: ready is purely "not full".
    assign tx_ready  = !fifo_full;
    assign txd       = txd_r;
    assign busy      = (state != ST_IDLE) || (fifo_count != '0);
    assign done      = frame_end;

    // Framing FSM: sequences start/data/parity/stop and drives the line register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            txd_r   <= 1'b1;
        end else begin
            if (fifo_pop) begin
                shreg   <= fifo_dout;
                par_bit <= parity_of(9'(fifo_dout), DATA_BITS, PARITY_MODE);
            end

            case (state)
                ST_IDLE: begin
                    div_cnt <= '0;
                    bit_idx <= '0;
                    if (!fifo_empty) begin
                        state <= ST_START;
                        txd_r <= 1'b0;
                    end else begin
                        txd_r <= 1'b1;
                    end
                end

                ST_START: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        bit_idx <= '0;
                        state   <= ST_DATA;
                        txd_r   <= shreg[0];
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
                            if (PARITY_MODE != PARITY_NONE) begin
                                state <= ST_PARITY;
                                txd_r <= par_bit;
                            end else begin
                                state <= ST_STOP;
                                txd_r <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= shreg >> 1;
                            txd_r   <= shreg[1];
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                ST_PARITY: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        bit_idx <= '0;
                        state   <= ST_STOP;
                        txd_r   <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        if (bit_idx == STOP_LAST) begin
                            bit_idx <= '0;
                            if (!fifo_empty) begin
                                state <= ST_START;
                                txd_r <= 1'b0;
                            end else begin
                                state <= ST_IDLE;
                                txd_r <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    div_cnt <= '0;
                    bit_idx <= '0;
                    txd_r   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four differently parameterised instances, each
// with its own reset, driver, accept sampler and line monitor. Accepted
// words go into a per-instance queue; the monitor rebuilds the expected
// line waveform of each frame from the word and the framing rules.
module tb_uart_tx_param;

    localparam int NI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int fin_cnt = 0;

    task automatic chk(input string nm, input bit ok, input longint a, input longint e);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, a, e);
    endtask

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int CD    = (g == 2) ? 3 : 4;
        localparam int DB    = (g == 2) ? 9 : (g == 3) ? 7 : 8;
        localparam int PM    = (g == 1) ? 1 : (g == 2) ? 2 : 0;
        localparam int SB    = (g >= 2) ? 2 : 1;
        localparam int FD    = (g == 2) ? 8 : (g == 3) ? 2 : 4;
        localparam int NBITS = 1 + DB + ((PM != 0) ? 1 : 0) + SB;
        localparam int FLEN  = CD * NBITS;
        localparam int ID    = g;

        logic          rst_n;
        logic [DB-1:0] tx_data;
        logic          tx_valid;
        logic          tx_ready;
        logic          txd;
        logic          busy;
        logic          done;
        logic [8:0]    exp_q [$];
        int            done_cnt = 0;

        uart_tx_param #(
            .CLK_DIV     (CD),
            .DATA_BITS   (DB),
            .PARITY_MODE (PM),
            .STOP_BITS   (SB),
            .FIFO_DEPTH  (FD)
        ) dut (
            .clk      (clk),
            .rst      (rst_n),
            .tx_data  (tx_data),
            .tx_valid (tx_valid),
            .tx_ready (tx_ready),
            .txd      (txd),
            .busy     (busy),
            .done     (done)
        );

        task automatic cb(input string nm, input logic a, input logic e);
            chk($sformatf("g%0d %s", ID, nm), a === e, longint'(a), longint'(e));
        endtask

        task automatic ci(input string nm, input int a, input int e);
            chk($sformatf("g%0d %s", ID, nm), a == e, longint'(a), longint'(e));
        endtask

        // Scoreboard feed: every handshake edge queues the word it carried.
        always @(posedge clk) begin
            if (rst_n === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1)
                exp_q.push_back(9'(tx_data));
        end

        // Count completed frames as seen on the done output.
        always @(negedge clk) begin
            if (done === 1'b1) done_cnt <= done_cnt + 1;
        end

        // Line monitor: on each start bit, pop the expected word and compare
        // the line and done, clock by clock, against the ideal frame.
        initial begin : mon
            logic [8:0] w;
            logic       expb [13];
            logic       p;
            int         bad;
            int         dbad;
            bit         aborted;
            bit         b2b;
            b2b = 1'b0;
            forever begin
                @(negedge clk);
                if (rst_n !== 1'b1) begin
                    exp_q.delete();
                    b2b = 1'b0;
                end else begin
                    if (b2b) begin
                        cb("back-to-back start bit", txd, 1'b0);
                        b2b = 1'b0;
                    end
                    if (txd !== 1'b0) begin
                        if (done !== 1'b0) cb("done outside frame", done, 1'b0);
                    end else if (exp_q.size() == 0) begin
                        ci("unexpected frame start", 1, 0);
                        repeat (FLEN) @(negedge clk);
                    end else begin
                        w = exp_q.pop_front();
                        p = (PM == 2);
                        for (int i = 0; i < 13; i++) expb[i] = 1'b1;
                        expb[0] = 1'b0;
                        for (int i = 0; i < DB; i++) begin
                            expb[1 + i] = w[i];
                            p = p ^ w[i];
                        end
                        if (PM != 0) expb[1 + DB] = p;
                        bad = 0;
                        dbad = 0;
                        aborted = 1'b0;
                        for (int k = 0; k < FLEN; k++) begin
                            if (k > 0) @(negedge clk);
                            if (rst_n !== 1'b1) begin
                                aborted = 1'b1;
                                break;
                            end
                            if (txd !== expb[k / CD]) bad++;
                            if (done !== (k == FLEN - 1)) dbad++;
                        end
                        if (aborted) begin
                            exp_q.delete();
                        end else begin
                            ci($sformatf("frame 0x%0h wrong line clocks", w), bad, 0);
                            ci("done misplaced clocks", dbad, 0);
                            b2b = (exp_q.size() != 0);
                        end
                    end
                end
            end
        end

        // Offer one word from a negedge; return on the negedge after accept.
        task automatic send(input logic [DB-1:0] w);
            int n;
            n = 0;
            tx_data  = w;
            tx_valid = 1'b1;
            while (tx_ready !== 1'b1 && n < 2 * FLEN + 20) begin
                @(negedge clk);
                n++;
            end
            if (tx_ready !== 1'b1) ci("accept wait cycles within bound", n, 0);
            @(negedge clk);
        endtask

        task automatic wait_idle();
            int n;
            n = 0;
            while (!(busy === 1'b0 && exp_q.size() == 0) && n < 40 * FLEN) begin
                @(negedge clk);
                n++;
            end
            cb("busy after drain", busy, 1'b0);
        endtask

        // Single word into an idle block: line falls after the second edge,
        // done lands on the last clock of the frame, busy drops right after.
        task automatic lat_test(input logic [DB-1:0] w);
            int n;
            cb("txd idle before accept", txd, 1'b1);
            tx_data  = w;
            tx_valid = 1'b1;
            cb("tx_ready while idle", tx_ready, 1'b1);
            @(negedge clk);
            tx_valid = 1'b0;
            cb("txd one edge after accept", txd, 1'b1);
            cb("busy one edge after accept", busy, 1'b1);
            @(negedge clk);
            cb("txd two edges after accept", txd, 1'b0);
            n = 0;
            while (done !== 1'b1 && n < FLEN + 8) begin
                @(negedge clk);
                n++;
            end
            ci("clocks from fall to done", n + 1, FLEN);
            cb("busy during done", busy, 1'b1);
            @(negedge clk);
            cb("busy after done", busy, 1'b0);
            cb("done one cycle wide", done, 1'b0);
        endtask

        initial begin : stim
            int            stall_at;
            int            d0;
            int            gap;
            int            nlow;
            logic [DB-1:0] base;

            rst_n    = 1'b0;
            tx_valid = 1'b0;
            tx_data  = '0;
            repeat (3) @(negedge clk);
            cb("reset txd", txd, 1'b1);
            cb("reset tx_ready", tx_ready, 1'b1);
            cb("reset busy", busy, 1'b0);
            cb("reset done", done, 1'b0);
            rst_n = 1'b1;
            @(negedge clk);

            lat_test(DB'(9'h0A5));
            wait_idle();

            // Hold valid with FD+2 distinct words from idle.
            base     = DB'($urandom);
            d0       = done_cnt;
            stall_at = -1;
            for (int i = 0; i < FD + 2; i++) begin
                if (tx_ready !== 1'b1 && stall_at < 0) stall_at = i;
                send(base + DB'(i));
                if (i == FD + 1) ci("frames done before last burst word", done_cnt - d0, 1);
            end
            tx_valid = 1'b0;
            ci("words accepted before tx_ready fell", stall_at, FD + 1);
            wait_idle();

            // Random words with short and long gaps; junk data while idle.
            for (int i = 0; i < 24; i++) begin
                gap = ($urandom_range(0, 3) == 0) ? $urandom_range(FLEN, 2 * FLEN)
                                                  : $urandom_range(0, 3);
                for (int j = 0; j < gap; j++) begin
                    tx_data = DB'($urandom);
                    @(negedge clk);
                end
                send(DB'($urandom));
                tx_valid = 1'b0;
            end
            wait_idle();

            // Reset in the data bits of a zero word with more words queued.
            for (int i = 0; i < 3; i++) send('0);
            tx_valid = 1'b0;
            repeat (2 * CD) @(negedge clk);
            cb("txd low in data bits", txd, 1'b0);
            cb("busy before reset", busy, 1'b1);
            #2;
            rst_n = 1'b0;
            #1;
            cb("txd async on reset", txd, 1'b1);
            cb("tx_ready in reset", tx_ready, 1'b1);
            cb("busy in reset", busy, 1'b0);
            cb("done in reset", done, 1'b0);
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            cb("tx_ready after release", tx_ready, 1'b1);
            cb("busy after release", busy, 1'b0);
            nlow = 0;
            repeat (2 * FLEN) begin
                @(negedge clk);
                if (txd !== 1'b1) nlow++;
            end
            ci("line low clocks after reset", nlow, 0);

            lat_test(DB'($urandom));
            wait_idle();
            repeat (4) @(negedge clk);
            fin_cnt++;
        end
    end

    initial begin
        wait (fin_cnt == NI);
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: finished instances %0d, expected %0d", fin_cnt, NI);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter CLK_DIV, default 10417: clocks per bit (9600 baud at 100 MHz); legal range 2..65535.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY_MODE, default 0: 0 = none, 1 = even, 2 = odd.
REQ-004 Parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4: transmit FIFO entries; power of two, at least 2.
REQ-006 clk  input  1  sole clock; all state changes on the rising edge.
REQ-007 rst  input  1  reset; asynchronous, active-low.
REQ-008 tx_data  input  DATA_BITS  word to send, sampled on handshake.
REQ-009 tx_valid  input  1  producer offers tx_data.
REQ-010 tx_ready  output  1  FIFO can accept a word.
REQ-011 txd  output  1  serial line, idle high.
REQ-012 busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-013 done  output  1  one-cycle pulse when the last stop bit of a frame completes.

Function
REQ-014 A word is accepted only on a rising edge where tx_valid and tx_ready are both high.
REQ-015 tx_ready is exactly "FIFO not full", with no credit for a same-cycle pop.
REQ-016 The FIFO has no bypass path; an accepted word is popped no earlier than the next edge.
REQ-017 The FSM has states IDLE, START, DATA, PARITY, STOP.
  - IDLE: on FIFO non-empty, pop and go to START.
  - START: send 0, then DATA.
  - DATA: send DATA_BITS bits LSB first, then PARITY if PARITY_MODE != 0, else STOP.
  - PARITY: send the parity bit, then STOP.
  - STOP: send STOP_BITS ones, then IDLE, or directly START if the FIFO is non-empty.
REQ-018 Every bit, including each stop bit, is driven for exactly CLK_DIV clocks.
REQ-019 The bit counter reloads at each frame start; it does not free-run, so there is no phase jitter against the accept edge.
REQ-020 For a word accepted at edge N into an empty, idle block, txd falls after edge N+1.
REQ-021 Frame length is CLK_DIV*(1+DATA_BITS+(PARITY_MODE!=0)+STOP_BITS) clocks.
REQ-022 Back-to-back frames have zero extra idle clocks between them.
REQ-023 Even parity is the XOR of the data bits; odd parity is its inverse.
REQ-024 The divider counter width is $clog2(CLK_DIV), and the divider wraps to 0 at CLK_DIV-1.
REQ-025 The bit index counter is sized for 9 data bits or 2 stop bits.
REQ-026 done asserts in the cycle the final stop bit's count expires, coincident with the transition out of STOP.
REQ-027 txd is driven from a register with no combinational path from inputs.

Reset
REQ-028 While rst is low:
  - txd = 1, tx_ready = 1, busy = 0, done = 0.
  - FSM = IDLE; FIFO pointers and count = 0; counters = 0.
REQ-029 Reset asserted mid-frame aborts the frame immediately and discards all queued words.
REQ-030 After rst deasserts, the first accept behaves as REQ-020.

Structure
REQ-031 Package uart_pkg holds the FSM state encoding and the PARITY_NONE/EVEN/ODD constants.
REQ-032 The FIFO is one sub-module, uart_fifo, parametrised by WIDTH and DEPTH, with push/pop/full/empty/count ports on the same clk and rst.

Verification
REQ-033 CLK_DIV=4, 8N1, send 0xA5 -> txd = 0,1,0,1,0,0,1,0,1,1, each held 4 clocks; done pulses once at clock 40 after the fall.
REQ-034 PARITY_MODE=1, then 2, send 0xA5 -> parity bit 0 (even) and 1 (odd) after bit 7; frame 44 clocks.
REQ-035 FIFO_DEPTH=4, tx_valid held high with 6 distinct words while idle -> 5 accepted, tx_ready low after the 5th, word 6 is accepted only after frame 1 ends, and all frames are emitted in order.
REQ-036 Two words accepted consecutively, CLK_DIV=4, 8N1 -> 80 contiguous frame clocks with no high gap beyond the stop bits; busy falls in the cycle after the second done.
REQ-037 rst pulsed low during the DATA bits of frame 1 with 2 words queued -> txd high asynchronously; no further frames; tx_ready = 1 and busy = 0 after release.
REQ-038 DATA_BITS=7, STOP_BITS=2, send 0x7F -> start bit, seven ones, two stop bits; frame 40 clocks at CLK_DIV=4.
